// File: rtl/clk_period_mon.sv
`default_nettype none
// ============================================================================
// clk_period_mon : measures the half-period of an asynchronous mon_clk in clk
//                  cycles and reports lock, too-fast and stuck status.
// Revision       : 1.0  initial release
// ============================================================================
module clk_period_mon #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16,
  parameter int LOCK_CNT    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mon_clk,
  input  logic             en,
  input  logic             clear,
  input  logic [CNT_W-1:0] min_half,
  input  logic [CNT_W-1:0] max_half,
  output logic [CNT_W-1:0] half_period,
  output logic             meas_valid,
  output logic             locked,
  output logic             too_fast,
  output logic             stuck
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_MEASURE = 2'd2,
    ST_FAULT   = 2'd3
  } state_t;

  localparam logic [3:0] LOCK_MAX = 4'(LOCK_CNT);

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       half_period_q, half_period_d;
  logic                   meas_valid_q, meas_valid_d;
  logic                   locked_q, locked_d;
  logic                   too_fast_q, too_fast_d;
  logic                   stuck_q, stuck_d;
  logic [3:0]             lock_cnt_q, lock_cnt_d;

  logic                   mon_edge;
  logic                   timeout;
  logic                   short_meas;
  logic                   new_fast;
  logic                   new_stuck;
  logic [CNT_W:0]         cnt_inc;
  logic [CNT_W-1:0]       meas_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      sync_q        <= '0;
      hist_q        <= 1'b0;
      cnt_q         <= '0;
      half_period_q <= '0;
      meas_valid_q  <= 1'b0;
      locked_q      <= 1'b0;
      too_fast_q    <= 1'b0;
      stuck_q       <= 1'b0;
      lock_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      sync_q        <= sync_d;
      hist_q        <= hist_d;
      cnt_q         <= cnt_d;
      half_period_q <= half_period_d;
      meas_valid_q  <= meas_valid_d;
      locked_q      <= locked_d;
      too_fast_q    <= too_fast_d;
      stuck_q       <= stuck_d;
      lock_cnt_q    <= lock_cnt_d;
    end
  end

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], mon_clk};
    hist_d     = sync_q[SYNC_STAGES-1];
    mon_edge   = sync_q[SYNC_STAGES-1] ^ hist_q;
    cnt_inc    = {1'b0, cnt_q} + (CNT_W+1)'(1);
    meas_val   = cnt_inc[CNT_W] ? '1 : cnt_inc[CNT_W-1:0];
    short_meas = cnt_inc < {1'b0, min_half};
    // An edge on the max_half cycle is a valid measurement, not a timeout
    timeout    = !mon_edge && (cnt_q == max_half);

    state_d       = state_q;
    cnt_d         = mon_edge ? '0 : ((&cnt_q) ? cnt_q : cnt_q + CNT_W'(1));
    half_period_d = half_period_q;
    meas_valid_d  = 1'b0;
    too_fast_d    = too_fast_q;
    stuck_d       = stuck_q;
    lock_cnt_d    = lock_cnt_q;
    new_fast      = 1'b0;
    new_stuck     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (en) state_d = ST_ACQUIRE;
      end
      ST_ACQUIRE: begin
        if (mon_edge) begin
          state_d = ST_MEASURE;
        end else if (timeout) begin
          stuck_d = 1'b1;
          state_d = ST_FAULT;
        end
      end
      ST_MEASURE: begin
        if (mon_edge) begin
          half_period_d = meas_val;
          meas_valid_d  = 1'b1;
          if (short_meas) begin
            too_fast_d = 1'b1;
            lock_cnt_d = '0;
            state_d    = ST_FAULT;
          end else if (lock_cnt_q != LOCK_MAX) begin
            lock_cnt_d = lock_cnt_q + 4'd1;
          end
        end else if (timeout) begin
          stuck_d    = 1'b1;
          lock_cnt_d = '0;
          state_d    = ST_FAULT;
        end
      end
      ST_FAULT: begin
        if (mon_edge) begin
          half_period_d = meas_val;
          meas_valid_d  = 1'b1;
          new_fast      = short_meas;
        end else begin
          // A saturated counter sitting on max_half must not re-trigger forever
          new_stuck = timeout && !stuck_q;
        end
        if (clear) begin
          too_fast_d = 1'b0;
          stuck_d    = 1'b0;
          lock_cnt_d = '0;
        end
        if (new_fast)  too_fast_d = 1'b1;
        if (new_stuck) stuck_d    = 1'b1;
        if (clear && !(new_fast || new_stuck)) begin
          state_d = ST_ACQUIRE;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!en) begin
      state_d       = ST_IDLE;
      cnt_d         = '0;
      half_period_d = '0;
      meas_valid_d  = 1'b0;
      too_fast_d    = 1'b0;
      stuck_d       = 1'b0;
      lock_cnt_d    = '0;
    end

    locked_d = (state_d == ST_MEASURE) && (lock_cnt_q == LOCK_MAX);
  end

  assign half_period = half_period_q;
  assign meas_valid  = meas_valid_q;
  assign locked      = locked_q;
  assign too_fast    = too_fast_q;
  assign stuck       = stuck_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_period_mon.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_clk_period_mon : scoreboard bench for clk_period_mon (plus a 4-bit
//                     counter instance for saturation).
// Revision          : 1.0  initial release
// ============================================================================
module tb_clk_period_mon;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mon_clk = 1'b0;
  logic        en = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] min_half = 16'd8;
  logic [15:0] max_half = 16'd12;
  logic [15:0] half_period;
  logic        meas_valid, locked, too_fast, stuck;

  logic        mon2 = 1'b0;
  logic        en2 = 1'b0;
  logic [3:0]  min2 = 4'd2;
  logic [3:0]  max2 = 4'd15;
  logic [3:0]  hp2;
  logic        mv2, lk2, tf2, st2;

  clk_period_mon #(.SYNC_STAGES(2), .CNT_W(16), .LOCK_CNT(4)) dut (
    .clk(clk), .rst_n(rst_n), .mon_clk(mon_clk), .en(en), .clear(clear),
    .min_half(min_half), .max_half(max_half), .half_period(half_period),
    .meas_valid(meas_valid), .locked(locked), .too_fast(too_fast), .stuck(stuck)
  );

  clk_period_mon #(.SYNC_STAGES(2), .CNT_W(4), .LOCK_CNT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .mon_clk(mon2), .en(en2), .clear(1'b0),
    .min_half(min2), .max_half(max2), .half_period(hp2),
    .meas_valid(mv2), .locked(lk2), .too_fast(tf2), .stuck(st2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  int last_tog = 0;
  bit measure_on = 1'b0;
  int exp_q[$];
  int mv2_cnt = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
  always @(negedge clk) if (mv2) mv2_cnt <= mv2_cnt + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Toggle mon_clk; the half-period it closes is the cycle gap since the last toggle
  task automatic tog();
    int g;
    g = cyc_cnt - last_tog;
    if (measure_on) exp_q.push_back(g > 65535 ? 65535 : g);
    last_tog = cyc_cnt;
    mon_clk  = ~mon_clk;
  endtask

  task automatic restart();
    en = 1'b0;
    measure_on = 1'b0;
    cyc(3);
    en = 1'b1;
    cyc(1);
  endtask

  always @(negedge clk) begin : monitor
    int e;
    if (meas_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_meas: got half_period %0d expected no meas_valid", half_period);
      end else begin
        e = exp_q.pop_front();
        chk("half_period", half_period, e);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    #2;
    chk("rst_half_period", half_period, 0);
    chk("rst_meas_valid", meas_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_too_fast", too_fast, 0);
    chk("rst_stuck", stuck, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);

    // Nominal lock at 10-cycle half-period, then stuck
    restart();
    tog();
    measure_on = 1'b1;
    repeat (3) begin cyc(10); tog(); end
    cyc(10);
    chk("lock_after3", locked, 0);
    tog();
    cyc(10);
    chk("lock_after4", locked, 1);
    chk("nominal_too_fast", too_fast, 0);
    cyc(4);
    chk("stuck_early", stuck, 0);
    chk("locked_before_stuck", locked, 1);
    cyc(2);
    chk("stuck_set", stuck, 1);
    chk("locked_on_stuck", locked, 0);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    chk("stuck_cleared", stuck, 0);
    n = 0;
    while (!stuck && n < 40) begin cyc(1); n++; end
    chk("restuck_delay_ok", (n >= 12 && n <= 14), 1);

    // Too fast, then clear and re-lock at 10
    restart();
    tog();
    measure_on = 1'b1;
    repeat (4) begin cyc(4); tog(); end
    cyc(4);
    chk("too_fast_set", too_fast, 1);
    chk("too_fast_locked", locked, 0);
    chk("too_fast_stuck", stuck, 0);
    cyc(6);
    tog();
    cyc(5);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    measure_on = 1'b0;
    chk("too_fast_cleared", too_fast, 0);
    cyc(4);
    tog();
    measure_on = 1'b1;
    repeat (3) begin cyc(10); tog(); end
    cyc(10);
    chk("relock_after3", locked, 0);
    tog();
    cyc(10);
    chk("relock_after4", locked, 1);
    chk("relock_too_fast", too_fast, 0);

    // Boundaries: 8 and 12 legal, 13 via edge legal, 7 too fast
    restart();
    tog();
    measure_on = 1'b1;
    repeat (5) begin cyc(8); tog(); end
    repeat (3) begin cyc(12); tog(); end
    cyc(13);
    tog();
    cyc(4);
    chk("bound_stuck", stuck, 0);
    chk("bound_too_fast", too_fast, 0);
    chk("bound_locked", locked, 1);
    cyc(7);
    tog();
    cyc(7);
    tog();
    cyc(4);
    chk("bound7_too_fast", too_fast, 1);
    chk("bound7_locked", locked, 0);

    // Enable drop while locked
    restart();
    tog();
    measure_on = 1'b1;
    repeat (4) begin cyc(10); tog(); end
    cyc(10);
    chk("en_locked", locked, 1);
    en = 1'b0;
    cyc(1);
    chk("en_off_locked", locked, 0);
    chk("en_off_half_period", half_period, 0);
    chk("en_off_meas_valid", meas_valid, 0);
    chk("en_off_too_fast", too_fast, 0);
    chk("en_off_stuck", stuck, 0);
    en = 1'b1;
    measure_on = 1'b0;
    cyc(1);
    tog();
    cyc(10);
    measure_on = 1'b1;
    tog();
    cyc(5);

    // Asynchronous reset mid-count
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_half_period", half_period, 0);
    chk("async_meas_valid", meas_valid, 0);
    chk("async_locked", locked, 0);
    en = 1'b0;
    rst_n = 1'b1;
    measure_on = 1'b0;
    cyc(4);
    en = 1'b1;
    cyc(1);
    tog();
    cyc(10);
    measure_on = 1'b1;
    tog();
    cyc(6);
    chk("queue_empty", exp_q.size(), 0);

    // 4-bit counter saturation
    en2 = 1'b1;
    n = 0;
    while (!st2 && n < 40) begin cyc(1); n++; end
    chk("sat_stuck_delay_ok", (n >= 15 && n <= 17), 1);
    cyc(20);
    chk("sat_stuck_held", st2, 1);
    chk("sat_no_meas", mv2_cnt, 0);
    mon2 = 1'b1;
    n = 0;
    while (!mv2 && n < 8) begin cyc(1); n++; end
    chk("sat_meas_seen", mv2, 1);
    chk("sat_half_period", hp2, 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
